// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
// Receives a little-endian byte stream from a host, assembles 19-bit
// instructions (3 bytes each) and writes them to instruction memory at
// consecutive addresses. A trailing XOR checksum byte validates the image.
// The pipeline is held in reset until a complete, checksum-clean image is
// in memory.
//
// Stream format: N_lo N_hi { B0 B1 B2 } x N  CHK
//   word = {B2[2:0], B1, B0}, B2[7:3] must be zero
//   CHK  = XOR of every byte from N_lo through the last B2
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   begins a load (only honoured in IDLE, DONE or ERR)
//   inData    in   host byte
//   inValid   in   host byte valid
//   inReady   out  loader accepts a byte this cycle
//   imemAddr  out  instruction-memory write address
//   imemData  out  instruction-memory write data
//   imemWe    out  instruction-memory write strobe (one cycle per word)
//   cpuRst    out  pipeline reset, released only after a good load
//   done      out  image loaded and checksum good (level)
//   error     out  load failed (level)
// -----------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int INSTR_W = 19,
    parameter int ADDR_W  = 12,
    parameter int DEPTH   = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         inData,
    input  logic               inValid,
    output logic               inReady,
    output logic [ADDR_W-1:0]  imemAddr,
    output logic [INSTR_W-1:0] imemData,
    output logic               imemWe,
    output logic               cpuRst,
    output logic               done,
    output logic               error
);

    // Word counter is one bit wider than the address so N == DEPTH never wraps.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_HDR0 = 4'd1,
        S_HDR1 = 4'd2,
        S_B0   = 4'd3,
        S_B1   = 4'd4,
        S_B2   = 4'd5,
        S_CHK  = 4'd6,
        S_DONE = 4'd7,
        S_ERR  = 4'd8
    } state_t;

    // Running checksum update.
    function automatic logic [7:0] f_chk_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    // High byte of a word may only carry the top three instruction bits.
    function automatic logic f_hi_illegal(input logic [7:0] b);
        return |b[7:3];
    endfunction

    // Assemble an instruction from its three bytes.
    function automatic logic [INSTR_W-1:0] f_word(input logic [7:0] b2, input logic [7:0] b1,
                                                  input logic [7:0] b0);
        return INSTR_W'({b2[2:0], b1, b0});
    endfunction

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [7:0]          r_chk;
    logic [15:0]         r_n;
    logic [7:0]          r_b0;
    logic [7:0]          r_b1;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [INSTR_W-1:0]  r_data;
    logic                r_in_ready;
    logic                r_cpu_rst;
    logic                r_done;
    logic                r_error;

    logic                w_xfer;
    logic                w_start_ok;
    logic [15:0]         w_n_hdr;
    logic                w_n_bad;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_last_word;
    logic                w_in_ready_nxt;
    logic                w_cpu_rst_nxt;
    logic                w_done_nxt;
    logic                w_error_nxt;

    assign w_xfer      = inValid && r_in_ready;
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
    assign w_n_hdr     = {inData, r_n[7:0]};
    assign w_n_bad     = (w_n_hdr == 16'd0) || ({1'b0, w_n_hdr} > DEPTH_L);
    assign w_cnt_inc   = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    assign w_last_word = ({{(16-CNT_W){1'b0}}, w_cnt_inc} == r_n);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; every byte-taking state advances only on a transfer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) w_next = S_HDR0;
                else       w_next = r_state;
            end
            S_HDR0: begin
                if (w_xfer) w_next = S_HDR1;
                else        w_next = r_state;
            end
            S_HDR1: begin
                if (w_xfer) begin
                    if (w_n_bad) w_next = S_ERR;
                    else         w_next = S_B0;
                end else begin
                    w_next = r_state;
                end
            end
            S_B0: begin
                if (w_xfer) w_next = S_B1;
                else        w_next = r_state;
            end
            S_B1: begin
                if (w_xfer) w_next = S_B2;
                else        w_next = r_state;
            end
            S_B2: begin
                if (w_xfer) begin
                    if (f_hi_illegal(inData)) w_next = S_ERR;
                    else if (w_last_word)     w_next = S_CHK;
                    else                      w_next = S_B0;
                end else begin
                    w_next = r_state;
                end
            end
            S_CHK: begin
                if (w_xfer) begin
                    if (inData == r_chk) w_next = S_DONE;
                    else                 w_next = S_ERR;
                end else begin
                    w_next = r_state;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode from the next state so the status outputs can be registered
    // yet still line up with the state they describe.
    always_comb begin
        w_in_ready_nxt = 1'b0;
        w_cpu_rst_nxt  = 1'b1;
        w_done_nxt     = 1'b0;
        w_error_nxt    = 1'b0;
        case (w_next)
            S_HDR0, S_HDR1, S_B0, S_B1, S_B2, S_CHK: w_in_ready_nxt = 1'b1;
            S_DONE: begin
                w_cpu_rst_nxt = 1'b0;
                w_done_nxt    = 1'b1;
            end
            S_ERR:   w_error_nxt = 1'b1;
            default: w_in_ready_nxt = 1'b0;
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready <= 1'b0;
            r_cpu_rst  <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_in_ready <= w_in_ready_nxt;
            r_cpu_rst  <= w_cpu_rst_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
        end
    end

    // Datapath: header capture, byte assembly, checksum and memory write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_chk  <= 8'd0;
            r_n    <= 16'd0;
            r_b0   <= 8'd0;
            r_b1   <= 8'd0;
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_start_ok) begin
                r_cnt <= '0;
                r_chk <= 8'd0;
            end else if (w_xfer) begin
                // Folding in the CHK byte too is harmless: the compare has already used r_chk.
                r_chk <= f_chk_update(r_chk, inData);
                case (r_state)
                    S_HDR0: r_n[7:0]  <= inData;
                    S_HDR1: r_n[15:8] <= inData;
                    S_B0:   r_b0      <= inData;
                    S_B1:   r_b1      <= inData;
                    S_B2: begin
                        if (!f_hi_illegal(inData)) begin
                            r_we   <= 1'b1;
                            r_addr <= r_cnt[ADDR_W-1:0];
                            r_data <= f_word(inData, r_b1, r_b0);
                            r_cnt  <= w_cnt_inc;
                        end
                    end
                    default: r_we <= 1'b0;
                endcase
            end
        end
    end

    assign inReady  = r_in_ready;
    assign imemWe   = r_we;
    assign imemAddr = r_addr;
    assign imemData = r_data;
    assign cpuRst   = r_cpu_rst;
    assign done     = r_done;
    assign error    = r_error;

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  inData;
    logic        inValid;
    logic        inReady;
    logic [11:0] imemAddr;
    logic [18:0] imemData;
    logic        imemWe;
    logic        cpuRst;
    logic        done;
    logic        error;

    int          n_checks  = 0;
    int          n_errors  = 0;
    int          wr_count  = 0;
    int          wc_before = 0;
    logic [11:0] last_addr = 12'd0;
    logic [11:0] exp_addr  = 12'd0;
    logic [30:0] sb[$];
    logic [18:0] words[$];
    logic [30:0] mon_e;

    always #5 clk = ~clk;

    imem_boot_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .inData   (inData),
        .inValid  (inValid),
        .inReady  (inReady),
        .imemAddr (imemAddr),
        .imemData (imemData),
        .imemWe   (imemWe),
        .cpuRst   (cpuRst),
        .done     (done),
        .error    (error)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every write must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && imemWe) begin
            wr_count++;
            last_addr = imemAddr;
            if (sb.size() == 0) begin
                check_eq("write_expected", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check_eq("wr_addr", {20'd0, imemAddr}, {20'd0, mon_e[30:19]});
                check_eq("wr_data", {13'd0, imemData}, {13'd0, mon_e[18:0]});
            end
        end
    end

    // Present one byte (after an optional random gap) and wait until it transfers.
    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int gap;
        int t;
        gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        inValid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        inValid = 1'b1;
        inData  = b;
        t = 0;
        while (!inReady && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!inReady) begin
            check_eq("ready_timeout", 32'(t), 32'd0);
        end else begin
            @(posedge clk);
            #1;
        end
        inValid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        exp_addr = 12'd0;
    endtask

    // Send a full image built from words[]; bad_xor corrupts the checksum byte.
    task automatic run_image(input logic [15:0] n, input int maxgap, input logic [7:0] bad_xor);
        logic [7:0]  cs;
        logic [7:0]  b;
        logic [18:0] w;
        cs = 8'd0;
        b = n[7:0];  cs = cs ^ b; send_byte(b, maxgap);
        b = n[15:8]; cs = cs ^ b; send_byte(b, maxgap);
        for (int i = 0; i < words.size(); i++) begin
            w = words[i];
            sb.push_back({exp_addr, w});
            exp_addr = exp_addr + 12'd1;
            b = w[7:0];              cs = cs ^ b; send_byte(b, maxgap);
            b = w[15:8];             cs = cs ^ b; send_byte(b, maxgap);
            b = {5'd0, w[18:16]};    cs = cs ^ b; send_byte(b, maxgap);
        end
        send_byte(cs ^ bad_xor, maxgap);
    endtask

    task automatic check_status(input string tag, input logic e_done, input logic e_err,
                                input logic e_cpurst, input logic e_ready);
        check_eq({tag, "_done"},    {31'd0, done},    {31'd0, e_done});
        check_eq({tag, "_error"},   {31'd0, error},   {31'd0, e_err});
        check_eq({tag, "_cpuRst"},  {31'd0, cpuRst},  {31'd0, e_cpurst});
        check_eq({tag, "_inReady"}, {31'd0, inReady}, {31'd0, e_ready});
    endtask

    task automatic check_reset_vals(input string tag);
        check_status(tag, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq({tag, "_we"},   {31'd0, imemWe},   32'd0);
        check_eq({tag, "_addr"}, {20'd0, imemAddr}, 32'd0);
        check_eq({tag, "_data"}, {13'd0, imemData}, 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        inValid = 1'b0;
        inData  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Good load: 02 00 FF FF 07 45 23 01 62
        words = '{19'h7FFFF, 19'h12345};
        do_start();
        run_image(16'd2, 0, 8'h00);
        check_status("good", 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("good_sb_empty", 32'(sb.size()), 32'd0);
        check_eq("good_wr_count", 32'(wr_count), 32'd2);

        // Bad checksum (0x63), then bytes after the error are not accepted.
        do_start();
        check_status("restart", 1'b0, 1'b0, 1'b1, 1'b1);
        run_image(16'd2, 0, 8'h01);
        check_status("badchk", 1'b0, 1'b1, 1'b1, 1'b0);
        inValid = 1'b1;
        inData  = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        check_eq("err_no_consume", {31'd0, inReady}, 32'd0);
        inValid = 1'b0;

        // Reload with random gaps on inValid.
        do_start();
        run_image(16'd2, 4, 8'h00);
        check_status("gaps", 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("gaps_wr_count", 32'(wr_count), 32'd6);

        // Header N = 0.
        wc_before = wr_count;
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check_status("n0", 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("n0_no_write", 32'(wr_count), 32'(wc_before));

        // Header N = 4097.
        do_start();
        send_byte(8'h01, 0);
        send_byte(8'h10, 0);
        check_status("n4097", 1'b0, 1'b1, 1'b1, 1'b0);

        // Illegal high bits in B2.
        wc_before = wr_count;
        do_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h08, 0);
        @(posedge clk);
        #1;
        check_status("hibits", 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("hibits_no_write", 32'(wr_count), 32'(wc_before));

        // Reset after B1 of word 0, then a full reload.
        do_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h11, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("midrst");
        rst = 1'b0;
        @(posedge clk);
        #1;
        words = '{19'h7FFFF, 19'h12345};
        do_start();
        run_image(16'd2, 2, 8'h00);
        check_status("after_rst", 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("after_rst_sb_empty", 32'(sb.size()), 32'd0);

        // Maximum image: N = 4096.
        words.delete();
        for (int i = 0; i < 4096; i++) begin
            words.push_back(19'((i * 7919 + 3) & 32'h7FFFF));
        end
        wc_before = wr_count;
        do_start();
        run_image(16'd4096, 0, 8'h00);
        check_status("max", 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("max_wr_count", 32'(wr_count - wc_before), 32'd4096);
        check_eq("max_last_addr", {20'd0, last_addr}, 32'hFFF);
        check_eq("max_sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
